// File: rtl/cbg_port_arbiter_pkg.sv
// cbg_port_arbiter_pkg: buffer geometry (F_D depth, A_W address width) and port controller state encoding
package cbg_port_arbiter_pkg;
  localparam int F_D = 16;
  localparam int A_W = $clog2(F_D);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FLUSH = 2'd3} state_t;
endpackage

// File: rtl/cbg_port_arbiter_if.sv
// cbg_port_arbiter_if: PE-side requests (en, wr_req, rd_req, drain_req, flush_req) and buffer-side grants/controls/status (wr_gnt, rd_gnt, buf_*, count, busy, drain_done)
interface cbg_port_arbiter_if
  import cbg_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CW = $clog2(F_D + 1)
);
  logic en, drain_req, flush_req;
  logic [NUM_REQ-1:0] wr_req, rd_req, wr_gnt, rd_gnt;
  logic buf_en, buf_we, buf_re, buf_flush, busy, drain_done;
  logic [CW-1:0] count;
  modport master (
    output en, wr_req, rd_req, drain_req, flush_req,
    input wr_gnt, rd_gnt, buf_en, buf_we, buf_re, buf_flush, count, busy, drain_done
  );
  modport slave (
    input en, wr_req, rd_req, drain_req, flush_req,
    output wr_gnt, rd_gnt, buf_en, buf_we, buf_re, buf_flush, count, busy, drain_done
  );
endinterface

// File: rtl/cbg_port_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick of first req at index >= ptr with wrap; ports req, ptr in, one-hot gnt and next_ptr (winner+1, or ptr if none) out
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);
  int idx;
  logic hit;
  always_comb begin
    gnt = '0;
    next_ptr = ptr;
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!hit && req[idx]) begin
        hit = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = PW'((idx + 1) % N);
      end
    end
  end
endmodule

// File: rtl/cbg_port_arbiter.sv
// cbg_port_arbiter: round-robin write/read port controller for a shared CBG buffer with drain/flush sequencing; ports clk, rst_n (sync active-low), bus (slave modport)
module cbg_port_arbiter
  import cbg_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH = F_D,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst_n,
  cbg_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  state_t state, nxt;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [NUM_REQ-1:0] wr_win, rd_win;
  logic [CW-1:0] count;
  logic run, rd_ok, wr_ok, rd_any, wr_any, drain_fl;
  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (.req(bus.wr_req), .ptr(wr_ptr), .gnt(wr_win), .next_ptr(wr_nxt));
  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (.req(bus.rd_req), .ptr(rd_ptr), .gnt(rd_win), .next_ptr(rd_nxt));
  assign run = state == RUN && bus.en;
  assign rd_ok = (run || state == DRAIN) && count != '0;
  assign rd_any = rd_ok && |rd_win;
  assign wr_ok = run && (count < CW'(DEPTH) || rd_any);
  assign wr_any = wr_ok && |wr_win;
  assign bus.wr_gnt = wr_any ? wr_win : '0;
  assign bus.rd_gnt = rd_any ? rd_win : '0;
  assign bus.buf_en = state == RUN || state == DRAIN;
  assign bus.buf_we = wr_any;
  assign bus.buf_re = rd_any;
  assign bus.buf_flush = state == FLUSH;
  assign bus.drain_done = state == FLUSH && drain_fl;
  assign bus.count = count;
  assign bus.busy = state != IDLE;
  always_comb begin
    nxt = bus.flush_req ? FLUSH
        : state == IDLE  ? (bus.en ? RUN : IDLE)
        : state == RUN   ? (bus.drain_req ? DRAIN : bus.en ? RUN : IDLE)
        : state == DRAIN ? (count == '0 && !rd_any ? FLUSH : DRAIN)
        : (bus.en ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      drain_fl <= 1'b0;
    end else begin
      state <= nxt;
      drain_fl <= state == DRAIN && nxt == FLUSH && !bus.flush_req;
      count <= state == FLUSH ? '0 : count + CW'(wr_any) - CW'(rd_any);
      wr_ptr <= state == FLUSH ? '0 : wr_any ? wr_nxt : wr_ptr;
      rd_ptr <= state == FLUSH ? '0 : rd_any ? rd_nxt : rd_ptr;
    end
  end
  always_ff @(posedge clk)
    if (rst_n) assert (!(wr_any && !rd_any && count == CW'(DEPTH)) && !(rd_any && !wr_any && count == '0));
endmodule

// File: tb/tb_cbg_port_arbiter.sv
// tb_cbg_port_arbiter: directed-vector self-checking bench for cbg_port_arbiter
module tb_cbg_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  cbg_port_arbiter_if #(.NUM_REQ(4), .CW(5)) bus ();
  cbg_port_arbiter #(.NUM_REQ(4), .DEPTH(16), .CW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.en = 1'b0;
    bus.wr_req = '0;
    bus.rd_req = '0;
    bus.drain_req = 1'b0;
    bus.flush_req = 1'b0;
    repeat (2) tick;
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_buf_en", 32'(bus.buf_en), 0);
    check("rst_gnt", 32'({bus.wr_gnt, bus.rd_gnt}), 0);
    rst_n = 1'b1;
    tick;
    #1;
    check("idle_no_en", 32'(bus.busy), 0);
    bus.en = 1'b1;
    bus.wr_req = 4'b1111;
    tick;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_wr_gnt", 32'(bus.wr_gnt), 32'(1) << i);
      tick;
      #1;
    end
    bus.wr_req = '0;
    #1;
    check("rr_count4", 32'(bus.count), 4);
    check("run_buf_en", 32'(bus.buf_en), 1);
    bus.wr_req = 4'b0001;
    repeat (12) tick;
    #1;
    check("full_count", 32'(bus.count), 16);
    check("full_no_wr", 32'(bus.wr_gnt), 0);
    bus.rd_req = 4'b0100;
    #1;
    check("full_rw_wr", 32'(bus.wr_gnt), 1);
    check("full_rw_rd", 32'(bus.rd_gnt), 4);
    check("full_rw_we_re", 32'({bus.buf_we, bus.buf_re}), 3);
    tick;
    bus.rd_req = '0;
    #1;
    check("full_rw_count", 32'(bus.count), 16);
    check("full_wr_only", 32'({bus.wr_gnt, bus.buf_we}), 0);
    bus.wr_req = '0;
    bus.rd_req = 4'b1000;
    repeat (16) tick;
    bus.rd_req = 4'b1111;
    #1;
    check("empty_count", 32'(bus.count), 0);
    check("empty_rd_gnt", 32'(bus.rd_gnt), 0);
    tick;
    #1;
    check("empty_rd_gnt2", 32'(bus.rd_gnt), 0);
    bus.wr_req = 4'b0001;
    #1;
    check("empty_wr_gnt", 32'(bus.wr_gnt), 1);
    check("empty_rd_gnt3", 32'(bus.rd_gnt), 0);
    tick;
    bus.wr_req = '0;
    #1;
    check("rd_ptr_hold", 32'(bus.rd_gnt), 1);
    check("one_count", 32'(bus.count), 1);
    tick;
    bus.rd_req = '0;
    #1;
    check("one_read_count", 32'(bus.count), 0);
    bus.wr_req = 4'b0001;
    repeat (5) tick;
    bus.wr_req = 4'b1111;
    bus.rd_req = 4'b0001;
    bus.drain_req = 1'b1;
    #1;
    check("pre_drain_count", 32'(bus.count), 5);
    check("pre_drain_wr", 32'(bus.wr_gnt), 2);
    check("pre_drain_rd", 32'(bus.rd_gnt), 1);
    tick;
    bus.drain_req = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("drain_wr_gnt", 32'(bus.wr_gnt), 0);
      check("drain_rd_gnt", 32'(bus.rd_gnt), 1);
      check("drain_count", 32'(bus.count), 32'(5 - i));
      tick;
      #1;
    end
    check("drained_count", 32'(bus.count), 0);
    check("drained_rd_gnt", 32'(bus.rd_gnt), 0);
    check("drained_no_flush", 32'(bus.buf_flush), 0);
    check("drained_busy", 32'(bus.busy), 1);
    tick;
    bus.wr_req = '0;
    bus.rd_req = '0;
    #1;
    check("drain_flush", 32'(bus.buf_flush), 1);
    check("drain_done", 32'(bus.drain_done), 1);
    check("flush_buf_en", 32'(bus.buf_en), 0);
    tick;
    #1;
    check("post_flush", 32'({bus.buf_flush, bus.drain_done}), 0);
    check("post_flush_run", 32'({bus.busy, bus.buf_en}), 3);
    bus.wr_req = 4'b1111;
    #1;
    check("ptr_reset_wr", 32'(bus.wr_gnt), 1);
    tick;
    bus.wr_req = 4'b0001;
    repeat (8) tick;
    bus.wr_req = '0;
    bus.flush_req = 1'b1;
    bus.drain_req = 1'b1;
    #1;
    check("pre_flush_count", 32'(bus.count), 9);
    tick;
    bus.flush_req = 1'b0;
    bus.drain_req = 1'b0;
    #1;
    check("flush_pulse", 32'(bus.buf_flush), 1);
    check("flush_no_done", 32'(bus.drain_done), 0);
    check("flush_count_held", 32'(bus.count), 9);
    tick;
    #1;
    check("flush_count0", 32'(bus.count), 0);
    check("flush_to_run", 32'({bus.busy, bus.buf_flush}), 2);
    bus.en = 1'b0;
    tick;
    #1;
    check("run_to_idle", 32'(bus.busy), 0);
    bus.en = 1'b1;
    tick;
    #1;
    check("idle_to_run", 32'(bus.busy), 1);
    bus.wr_req = 4'b0001;
    repeat (3) tick;
    bus.wr_req = '0;
    bus.drain_req = 1'b1;
    tick;
    bus.drain_req = 1'b0;
    #1;
    check("drain3_count", 32'(bus.count), 3);
    check("drain3_state", 32'({bus.busy, bus.buf_en}), 3);
    rst_n = 1'b0;
    bus.rd_req = 4'b1111;
    tick;
    #1;
    check("rst_drain_busy", 32'(bus.busy), 0);
    check("rst_drain_count", 32'(bus.count), 0);
    check("rst_drain_gnt", 32'({bus.wr_gnt, bus.rd_gnt}), 0);
    check("rst_drain_buf", 32'({bus.buf_en, bus.buf_we, bus.buf_re, bus.buf_flush, bus.drain_done}), 0);
    rst_n = 1'b1;
    bus.rd_req = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
